// File: rtl/tt_pin_frame_mux.sv
// -----------------------------------------------------------------------------
// tt_pin_frame_mux
//
// Time-multiplexes a wide CPU bus word (address + control strobes) onto the
// dedicated tile outputs over a repeating frame of PHASES clocks. External
// latches key off `phase` to rebuild the full word. The block also owns the
// bidirectional data pins and generates the CPU step enable, so the CPU only
// advances once per frame.
//
// Passthrough mode (mux_en=0) drops the framing. The low slice of the word is
// presented every clock, and the CPU steps every enabled clock.
//
// Ports:
//   clk, rst_n   system clock, asynchronous active-low reset
//   ena          tile enable; 0 freezes all state and holds the CPU
//   mux_en       1 = framed mode, 0 = passthrough (sampled at frame boundary)
//   out_word     CPU bus word to present (OUT_WIDTH bits)
//   data_out     CPU write data
//   data_oe      CPU drives the data bus
//   uio_in       bidir pins, input path
//   uo_out       dedicated outputs (one slice per phase)
//   uio_out      bidir pins, output path (stable for a whole frame)
//   uio_oe       bidir output enables (stable for a whole frame)
//   data_in      read data captured from uio_in for the CPU
//   phase        current phase index
//   frame_start  high while phase == 0
//   cpu_clk_en   CPU advance strobe
//
// SAMPLE_PHASE must be less than PHASES.
// -----------------------------------------------------------------------------
module tt_pin_frame_mux #(
  parameter int OUT_WIDTH    = 24,
  parameter int PIN_WIDTH    = 8,
  parameter int SAMPLE_PHASE = (OUT_WIDTH + PIN_WIDTH - 1) / PIN_WIDTH - 1,
  localparam int PHASES      = (OUT_WIDTH + PIN_WIDTH - 1) / PIN_WIDTH,
  localparam int PW          = (PHASES > 1) ? $clog2(PHASES) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ena,
  input  logic                 mux_en,
  input  logic [OUT_WIDTH-1:0] out_word,
  input  logic [PIN_WIDTH-1:0] data_out,
  input  logic                 data_oe,
  input  logic [PIN_WIDTH-1:0] uio_in,
  output logic [PIN_WIDTH-1:0] uo_out,
  output logic [PIN_WIDTH-1:0] uio_out,
  output logic [PIN_WIDTH-1:0] uio_oe,
  output logic [PIN_WIDTH-1:0] data_in,
  output logic [PW-1:0]        phase,
  output logic                 frame_start,
  output logic                 cpu_clk_en
);

  localparam int            PAD_WIDTH  = PHASES * PIN_WIDTH;
  localparam logic [PW-1:0] LAST_PHASE = PW'(PHASES - 1);
  localparam logic [PW-1:0] SAMPLE_IDX = PW'(SAMPLE_PHASE);

  logic                 mode_q;      // 1 = framing active for the current frame
  logic [PAD_WIDTH-1:0] snap;        // word captured at the frame's starting edge
  logic [PAD_WIDTH-1:0] padded;      // out_word zero-extended to whole slices
  logic [PAD_WIDTH-1:0] slice_src;
  logic                 fb;          // this enabled edge is a frame boundary
  logic [PW-1:0]        next_phase;
  logic [PIN_WIDTH-1:0] next_uo;

  assign padded = PAD_WIDTH'(out_word);

  // Passthrough is treated as a one-clock frame, so every edge is a boundary.
  // With PHASES=1 the framed mode degenerates to the same behaviour.
  assign fb = !mode_q || (phase == LAST_PHASE);

  // NOTE: every signal driven in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    next_phase = '0;
    if (mode_q && (phase != LAST_PHASE)) begin
      next_phase = phase + 1'b1;
    end
  end

  // Slice 0 comes from the live word: it is shown in the cycle right after
  // the edge that snapshots that same word. Later slices come from the
  // snapshot, so a mid-frame word change cannot tear the frame.
  always_comb begin
    slice_src = (next_phase == '0) ? padded : snap;
    next_uo   = slice_src[PIN_WIDTH-1:0];
    for (int k = 1; k < PHASES; k++) begin
      if (next_phase == PW'(k)) begin
        next_uo = slice_src[k*PIN_WIDTH +: PIN_WIDTH];
      end
    end
  end

  // The CPU steps on the same edge that takes the next snapshot. The
  // snapshot therefore holds the pre-step word.
  assign cpu_clk_en  = rst_n & ena & fb;
  assign frame_start = (phase == '0);

  // NOTE: sequential state uses non-blocking assignments, so every register
  // samples the pre-edge values, whatever the order of the statements.
  // NOTE: every register, including the snapshot, has a reset value. A
  // reset therefore returns the pins to a known idle state at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase   <= '0;
      mode_q  <= 1'b0;
      snap    <= '0;
      uo_out  <= '0;
      uio_out <= '0;
      uio_oe  <= '0;
      data_in <= '0;
    end else if (ena) begin
      phase  <= next_phase;
      uo_out <= next_uo;

      if (!mode_q || (phase == SAMPLE_IDX)) begin
        data_in <= uio_in;
      end

      // A mode change and the bidir pin state are taken only at a frame
      // boundary. Both stay constant across a frame.
      if (fb) begin
        mode_q  <= mux_en;
        snap    <= padded;
        uio_oe  <= {PIN_WIDTH{data_oe}};
        uio_out <= data_out;
      end
    end
  end

endmodule

// File: tb/tb_tt_pin_frame_mux.sv
// -----------------------------------------------------------------------------
// tb_tt_pin_frame_mux
//
// Self-checking bench for tt_pin_frame_mux at its default geometry
// (24-bit word, 8-bit pins, 3 phases, sample in phase 2).
//
// The reference model keeps the word that belongs to the current frame and
// the position within that frame. It predicts uo_out as slice `phase` of that
// word. Each scenario task drives stimulus through tick(). tick() compares
// every output against the model, and each task adds its own directed
// comparisons against constant values.
// -----------------------------------------------------------------------------
module tb_tt_pin_frame_mux;

  localparam int OUT_WIDTH    = 24;
  localparam int PIN_WIDTH    = 8;
  localparam int PHASES       = 3;
  localparam int SAMPLE_PHASE = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        ena = 1'b0;
  logic        mux_en = 1'b0;
  logic [23:0] out_word = '0;
  logic [7:0]  data_out = '0;
  logic        data_oe = 1'b0;
  logic [7:0]  uio_in = '0;
  logic [7:0]  uo_out, uio_out, uio_oe, data_in;
  logic [1:0]  phase;
  logic        frame_start, cpu_clk_en;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  bit          m_mode;
  int          m_phase;
  logic [23:0] m_frame;   // word that the current frame presents
  logic [7:0]  m_uio_out, m_uio_oe, m_din;

  tt_pin_frame_mux #(
    .OUT_WIDTH(OUT_WIDTH),
    .PIN_WIDTH(PIN_WIDTH),
    .SAMPLE_PHASE(SAMPLE_PHASE)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .ena(ena),
    .mux_en(mux_en),
    .out_word(out_word),
    .data_out(data_out),
    .data_oe(data_oe),
    .uio_in(uio_in),
    .uo_out(uo_out),
    .uio_out(uio_out),
    .uio_oe(uio_oe),
    .data_in(data_in),
    .phase(phase),
    .frame_start(frame_start),
    .cpu_clk_en(cpu_clk_en)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] slice_of(logic [23:0] w, int k);
    logic [23:0] s;
    s = w >> (8 * k);
    return s[7:0];
  endfunction

  function automatic void model_reset();
    m_mode    = 1'b0;
    m_phase   = 0;
    m_frame   = '0;
    m_uio_out = '0;
    m_uio_oe  = '0;
    m_din     = '0;
  endfunction

  // One enabled edge: a frame ends after PHASES clocks in framed mode, or
  // after every clock in passthrough. A new frame adopts the live word, the
  // pin state and the requested mode.
  function automatic void model_edge();
    bit ends_frame;
    ends_frame = !m_mode || (m_phase == PHASES - 1);
    if (!m_mode || m_phase == SAMPLE_PHASE) m_din = uio_in;
    if (ends_frame) begin
      m_mode    = mux_en;
      m_frame   = out_word;
      m_uio_oe  = data_oe ? 8'hFF : 8'h00;
      m_uio_out = data_out;
      m_phase   = 0;
    end else begin
      m_phase = m_phase + 1;
    end
  endfunction

  // Advance one clock. The combinational outputs are compared before the
  // edge, and the registered outputs 1 time unit after it.
  task automatic tick();
    logic       exp_en;
    logic [7:0] exp_uo;
    @(negedge clk);
    if (!rst_n) model_reset();
    exp_en = rst_n && ena && (!m_mode || m_phase == PHASES - 1);
    n_checks++;
    if (cpu_clk_en !== exp_en) begin
      n_fail++;
      $display("FAIL sb_cpu_clk_en: got %b expected %b (t=%0t)", cpu_clk_en, exp_en, $time);
    end
    n_checks++;
    if (frame_start !== (m_phase == 0)) begin
      n_fail++;
      $display("FAIL sb_frame_start: got %b expected %b (t=%0t)", frame_start, (m_phase == 0), $time);
    end
    @(posedge clk);
    if (!rst_n) model_reset();
    else if (ena) model_edge();
    #1;
    exp_uo = slice_of(m_frame, m_phase);
    n_checks++;
    if (phase !== 2'(m_phase)) begin
      n_fail++;
      $display("FAIL sb_phase: got %0d expected %0d (t=%0t)", phase, m_phase, $time);
    end
    n_checks++;
    if (uo_out !== exp_uo) begin
      n_fail++;
      $display("FAIL sb_uo_out: got %h expected %h (t=%0t)", uo_out, exp_uo, $time);
    end
    n_checks++;
    if (uio_out !== m_uio_out || uio_oe !== m_uio_oe) begin
      n_fail++;
      $display("FAIL sb_uio: got out=%h oe=%h expected out=%h oe=%h (t=%0t)", uio_out, uio_oe, m_uio_out, m_uio_oe, $time);
    end
    n_checks++;
    if (data_in !== m_din) begin
      n_fail++;
      $display("FAIL sb_data_in: got %h expected %h (t=%0t)", data_in, m_din, $time);
    end
  endtask

  task automatic align_phase(int target);
    for (int i = 0; i < 8 && m_phase != target; i++) tick();
    n_checks++;
    if (m_phase != target) begin
      n_fail++;
      $display("FAIL align_phase: reached %0d expected %0d", m_phase, target);
    end
  endtask

  task automatic test_reset();
    model_reset();
    #2 rst_n = 1'b0;
    ena = 1'b1;
    for (int i = 0; i < 4; i++) begin
      mux_en   = 1'($urandom);
      out_word = 24'($urandom);
      data_out = 8'($urandom);
      data_oe  = 1'($urandom);
      uio_in   = 8'($urandom);
      tick();
      n_checks++;
      if ({uo_out, uio_out, uio_oe, data_in, phase, cpu_clk_en} !== '0) begin
        n_fail++;
        $display("FAIL reset_outputs: got uo=%h uio=%h oe=%h din=%h ph=%0d en=%b expected all 0", uo_out, uio_out, uio_oe, data_in, phase, cpu_clk_en);
      end
    end
    // The first enabled edge after release is a frame boundary.
    mux_en   = 1'b1;
    out_word = 24'hC3_1234;
    data_oe  = 1'b0;
    data_out = 8'h00;
    rst_n    = 1'b1;
    tick();
    n_checks++;
    if (uo_out !== 8'h34 || phase !== 2'd0 || uio_oe !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_release: got uo=%h ph=%0d oe=%h expected uo=34 ph=0 oe=00", uo_out, phase, uio_oe);
    end
  endtask

  task automatic test_framed();
    logic [7:0] exp_uo [3] = '{8'h34, 8'h12, 8'hC3};
    for (int i = 0; i < 6; i++) begin
      n_checks++;
      if (uo_out !== exp_uo[i % 3] || phase !== 2'(i % 3)) begin
        n_fail++;
        $display("FAIL framed_uo: got uo=%h ph=%0d expected uo=%h ph=%0d", uo_out, phase, exp_uo[i % 3], i % 3);
      end
      n_checks++;
      if (cpu_clk_en !== (i % 3 == 2) || frame_start !== (i % 3 == 0)) begin
        n_fail++;
        $display("FAIL framed_strobes: got en=%b fs=%b expected en=%b fs=%b", cpu_clk_en, frame_start, (i % 3 == 2), (i % 3 == 0));
      end
      tick();
    end
  endtask

  task automatic test_word_change();
    logic [7:0] exp_uo [4] = '{8'hC3, 8'hCD, 8'hAB, 8'h00};
    align_phase(0);
    tick();                       // now in phase 1
    out_word = 24'h00_ABCD;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_checks++;
      if (uo_out !== exp_uo[i]) begin
        n_fail++;
        $display("FAIL word_change_%0d: got %h expected %h", i, uo_out, exp_uo[i]);
      end
    end
  endtask

  task automatic test_data_bus();
    align_phase(2);
    data_oe  = 1'b1;
    data_out = 8'h5A;
    tick();                       // frame boundary takes the pin state
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (uio_oe !== 8'hFF || uio_out !== 8'h5A) begin
        n_fail++;
        $display("FAIL data_bus_drive_%0d: got oe=%h out=%h expected oe=ff out=5a", i, uio_oe, uio_out);
      end
      data_oe  = 1'b0;
      data_out = 8'($urandom);
      if (i < 2) tick();
    end
    for (int i = 0; i < 6; i++) begin
      uio_in = (m_phase == SAMPLE_PHASE) ? 8'h77 : 8'h11;
      tick();
    end
    n_checks++;
    if (data_in !== 8'h77 || uio_oe !== 8'h00) begin
      n_fail++;
      $display("FAIL data_bus_sample: got din=%h oe=%h expected din=77 oe=00", data_in, uio_oe);
    end
  endtask

  task automatic test_ena_gating();
    align_phase(1);
    ena = 1'b0;
    for (int i = 0; i < 5; i++) begin
      out_word = 24'($urandom);
      uio_in   = 8'($urandom);
      data_out = 8'($urandom);
      data_oe  = 1'($urandom);
      tick();
      n_checks++;
      if (phase !== 2'd1 || cpu_clk_en !== 1'b0) begin
        n_fail++;
        $display("FAIL ena_freeze_%0d: got ph=%0d en=%b expected ph=1 en=0", i, phase, cpu_clk_en);
      end
    end
    ena = 1'b1;
    tick();
    n_checks++;
    if (phase !== 2'd2) begin
      n_fail++;
      $display("FAIL ena_resume: got ph=%0d expected 2", phase);
    end
  endtask

  task automatic test_mode_switch();
    align_phase(0);
    mux_en = 1'b0;
    tick();
    tick();
    n_checks++;
    if (phase !== 2'd2 || cpu_clk_en !== 1'b1) begin
      n_fail++;
      $display("FAIL mode_switch_hold: got ph=%0d en=%b expected ph=2 en=1", phase, cpu_clk_en);
    end
    tick();                       // frame boundary adopts passthrough
    for (int i = 0; i < 4; i++) begin
      out_word = 24'($urandom);
      uio_in   = 8'($urandom);
      tick();
      n_checks++;
      if (uo_out !== out_word[7:0] || data_in !== uio_in || phase !== 2'd0 || cpu_clk_en !== 1'b1 || frame_start !== 1'b1) begin
        n_fail++;
        $display("FAIL passthrough_%0d: got uo=%h din=%h ph=%0d en=%b fs=%b expected uo=%h din=%h ph=0 en=1 fs=1", i, uo_out, data_in, phase, cpu_clk_en, frame_start, out_word[7:0], uio_in);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    mux_en   = 1'b1;
    out_word = 24'hA5_5AF0;
    data_oe  = 1'b1;
    data_out = 8'h3C;
    tick();                       // passthrough boundary enters framed mode
    tick();                       // phase 1
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({uo_out, uio_out, uio_oe, data_in, phase, cpu_clk_en} !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_frame: got uo=%h uio=%h oe=%h din=%h ph=%0d en=%b expected all 0", uo_out, uio_out, uio_oe, data_in, phase, cpu_clk_en);
    end
    tick();
    rst_n = 1'b1;
    tick();                       // first edge is a boundary: stays in phase 0
    tick();
    n_checks++;
    if (phase !== 2'd1 || uo_out !== 8'h5A) begin
      n_fail++;
      $display("FAIL reset_restart: got ph=%0d uo=%h expected ph=1 uo=5a", phase, uo_out);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      ena      = ($urandom_range(7) != 0);
      if ($urandom_range(15) == 0) mux_en = ~mux_en;
      out_word = 24'($urandom);
      data_out = 8'($urandom);
      data_oe  = 1'($urandom);
      uio_in   = 8'($urandom);
      rst_n    = ($urandom_range(63) != 0);
      tick();
    end
    rst_n = 1'b1;
    ena   = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_framed();
    test_word_change();
    test_data_bus();
    test_ena_gating();
    test_mode_switch();
    test_reset_mid_frame();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
